// File: rtl/stream_to_axi_dma.sv
// Stream-to-memory write DMA: packs Avalon-ST frames into fixed-length AXI4 INCR write bursts.
// Base address, frame length and enable come from a small Avalon-MM register file.
//
// state    | meaning
// IDLE     | disabled, all handshakes low
// WAIT_SOP | dropping words until a start-of-packet is presented
// ADDR     | issuing the AW request for the next burst
// DATA     | forwarding stream words as W beats
// PAD      | filling the rest of a burst with zero-strobe beats after an early EOP
// RESP     | waiting for the B response of the current burst
module stream_to_axi_dma #(
    parameter int ADDR_WIDTH = 24,
    parameter int BURST_SIZE = 128
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [3:0]            mst_axi_awid,
    output logic [ADDR_WIDTH-1:0] mst_axi_awaddr,
    output logic [7:0]            mst_axi_awlen,
    output logic [2:0]            mst_axi_awsize,
    output logic [1:0]            mst_axi_awburst,
    output logic                  mst_axi_awlock,
    output logic [3:0]            mst_axi_awcache,
    output logic [2:0]            mst_axi_awprot,
    output logic [3:0]            mst_axi_awqos,
    output logic                  mst_axi_awvalid,
    input  logic                  mst_axi_awready,
    output logic [31:0]           mst_axi_wdata,
    output logic [3:0]            mst_axi_wstrb,
    output logic                  mst_axi_wlast,
    output logic                  mst_axi_wvalid,
    input  logic                  mst_axi_wready,
    input  logic [3:0]            mst_axi_bid,
    input  logic [1:0]            mst_axi_bresp,
    input  logic                  mst_axi_bvalid,
    output logic                  mst_axi_bready,
    input  logic [31:0]           st_data,
    input  logic                  st_valid,
    input  logic                  st_startofpacket,
    input  logic                  st_endofpacket,
    output logic                  st_ready,
    input  logic [4:0]            ctrl_address,
    input  logic                  ctrl_read,
    input  logic                  ctrl_write,
    input  logic [31:0]           ctrl_writedata,
    input  logic [3:0]            ctrl_byteenable,
    output logic [31:0]           ctrl_readdata,
    output logic [1:0]            ctrl_response,
    output logic                  ctrl_waitrequest
);

    localparam logic [7:0]            AWLEN       = 8'(BURST_SIZE - 1);
    localparam logic [ADDR_WIDTH-1:0] BURST_BYTES = ADDR_WIDTH'(BURST_SIZE * 4);

    typedef enum logic [2:0] {
        IDLE, WAIT_SOP, ADDR, DATA, PAD, RESP
    } state_t;

    state_t state, next_state;

    logic [ADDR_WIDTH-1:0] start_addr;
    logic [29:0]           words_number;
    logic                  enable;
    logic                  err_early_eop, err_missing_eop, err_bresp;
    logic [15:0]           frame_count;
    logic                  busy;

    logic [ADDR_WIDTH-1:0] curr_addr;
    logic [30:0]           words_left;
    logic [7:0]            beat_left;
    logic                  frame_done;

    logic sop_seen, aw_fire, beat_fire, pad_fire, b_fire;
    logic last_frame_word, last_beat;
    logic set_early, set_missing, set_bresp;

    logic [2:0]  reg_sel;
    logic [31:0] start_merged, words_merged;
    logic [2:0]  err_clr;
    logic        unused_ok;

    function automatic logic [31:0] apply_be(input logic [31:0] cur, input logic [31:0] wr,
                                             input logic [3:0] be);
        logic [31:0] res;
        res = cur;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) res[b*8 +: 8] = wr[b*8 +: 8];
        end
        return res;
    endfunction

    // register file
    assign reg_sel      = ctrl_address[4:2];
    assign start_merged = apply_be(32'(start_addr), ctrl_writedata, ctrl_byteenable);
    assign words_merged = apply_be({2'b00, words_number}, ctrl_writedata, ctrl_byteenable);
    assign err_clr      = (ctrl_write && reg_sel == 3'd3 && ctrl_byteenable[0]) ?
                          ctrl_writedata[3:1] : 3'b000;
    assign unused_ok    = ^{mst_axi_bid, ctrl_address[1:0], start_merged, words_merged[31:30]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_addr      <= '0;
            words_number    <= '0;
            enable          <= 1'b0;
            err_early_eop   <= 1'b0;
            err_missing_eop <= 1'b0;
            err_bresp       <= 1'b0;
        end else begin
            if (ctrl_write && reg_sel == 3'd0) start_addr <= start_merged[ADDR_WIDTH-1:0];
            if (ctrl_write && reg_sel == 3'd1) words_number <= words_merged[29:0];
            if (ctrl_write && reg_sel == 3'd2 && ctrl_byteenable[0]) enable <= ctrl_writedata[0];
            // a same-cycle error event wins over the write-one-to-clear
            err_early_eop   <= (err_early_eop   & ~err_clr[0]) | set_early;
            err_missing_eop <= (err_missing_eop & ~err_clr[1]) | set_missing;
            err_bresp       <= (err_bresp       & ~err_clr[2]) | set_bresp;
        end
    end

    assign busy = (state != IDLE);

    always_comb begin
        ctrl_readdata = 32'h0;
        if (ctrl_read) begin
            case (reg_sel)
                3'd0:    ctrl_readdata = 32'(start_addr);
                3'd1:    ctrl_readdata = {2'b00, words_number};
                3'd2:    ctrl_readdata = {31'h0, enable};
                3'd3:    ctrl_readdata = {frame_count, 12'h000, err_bresp, err_missing_eop,
                                          err_early_eop, busy};
                default: ctrl_readdata = 32'h0;
            endcase
        end
    end

    assign ctrl_response    = ((ctrl_read || ctrl_write) && reg_sel[2]) ? 2'b10 : 2'b00;
    assign ctrl_waitrequest = 1'b0;

    // constant AW attributes
    assign mst_axi_awid    = 4'h0;
    assign mst_axi_awlen   = AWLEN;
    assign mst_axi_awsize  = 3'b010;
    assign mst_axi_awburst = 2'b01;
    assign mst_axi_awlock  = 1'b0;
    assign mst_axi_awcache = 4'h0;
    assign mst_axi_awprot  = 3'h0;
    assign mst_axi_awqos   = 4'h0;
    assign mst_axi_awaddr  = curr_addr;
    assign mst_axi_wdata   = st_data;

    assign last_frame_word = (words_left == 31'd1);
    assign last_beat       = (beat_left == 8'd0);
    assign set_early       = beat_fire && st_endofpacket && !last_frame_word;
    assign set_missing     = beat_fire && last_frame_word && !st_endofpacket;
    assign set_bresp       = b_fire && (mst_axi_bresp != 2'b00);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state      = state;
        mst_axi_awvalid = 1'b0;
        mst_axi_wvalid  = 1'b0;
        mst_axi_wstrb   = 4'h0;
        mst_axi_wlast   = 1'b0;
        mst_axi_bready  = 1'b0;
        st_ready        = 1'b0;
        sop_seen        = 1'b0;
        aw_fire         = 1'b0;
        beat_fire       = 1'b0;
        pad_fire        = 1'b0;
        b_fire          = 1'b0;
        case (state)
            IDLE: begin
                if (enable) next_state = WAIT_SOP;
            end
            WAIT_SOP: begin
                // the SOP word stays on the bus so it becomes the first W beat
                st_ready = !(st_valid && st_startofpacket);
                if (!enable) begin
                    next_state = IDLE;
                end else if (st_valid && st_startofpacket) begin
                    sop_seen   = 1'b1;
                    next_state = ADDR;
                end
            end
            ADDR: begin
                mst_axi_awvalid = 1'b1;
                if (mst_axi_awready) begin
                    aw_fire    = 1'b1;
                    next_state = DATA;
                end
            end
            DATA: begin
                mst_axi_wvalid = st_valid;
                mst_axi_wstrb  = 4'hF;
                mst_axi_wlast  = last_beat;
                st_ready       = mst_axi_wready;
                if (st_valid && mst_axi_wready) begin
                    beat_fire = 1'b1;
                    if (last_beat)
                        next_state = RESP;
                    else if (st_endofpacket && !last_frame_word)
                        next_state = PAD;
                end
            end
            PAD: begin
                mst_axi_wvalid = 1'b1;
                mst_axi_wlast  = last_beat;
                if (mst_axi_wready) begin
                    pad_fire = 1'b1;
                    if (last_beat) next_state = RESP;
                end
            end
            RESP: begin
                mst_axi_bready = 1'b1;
                if (mst_axi_bvalid) begin
                    b_fire = 1'b1;
                    if (!enable)         next_state = IDLE;
                    else if (frame_done) next_state = WAIT_SOP;
                    else                 next_state = ADDR;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            curr_addr   <= '0;
            words_left  <= '0;
            beat_left   <= '0;
            frame_done  <= 1'b0;
            frame_count <= '0;
        end else begin
            if (sop_seen) begin
                curr_addr  <= start_addr;
                // a zero length register means the full 2^30-word frame
                words_left <= (words_number == 30'd0) ? 31'h4000_0000 : {1'b0, words_number};
                frame_done <= 1'b0;
            end
            if (aw_fire)
                beat_left <= AWLEN;
            else if (beat_fire || pad_fire)
                beat_left <= beat_left - 8'd1;
            if (beat_fire) begin
                words_left <= words_left - 31'd1;
                if (last_frame_word || st_endofpacket) frame_done <= 1'b1;
            end
            if (b_fire) begin
                curr_addr <= curr_addr + BURST_BYTES;
                if (frame_done) frame_count <= frame_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_stream_to_axi_dma.sv
// Directed/randomized bench for stream_to_axi_dma with a frame-level reference model.
module tb_stream_to_axi_dma;

    localparam int BURST = 4;
    localparam int AW    = 24;

    typedef struct packed { logic [31:0] d; logic sop; logic eop; } word_t;
    typedef struct packed { logic [31:0] d; logic [3:0] s; logic l; } beat_t;

    logic clk = 1'b0;
    logic rst;
    logic [3:0] mst_axi_awid;
    logic [AW-1:0] mst_axi_awaddr;
    logic [7:0] mst_axi_awlen;
    logic [2:0] mst_axi_awsize;
    logic [1:0] mst_axi_awburst;
    logic mst_axi_awlock;
    logic [3:0] mst_axi_awcache;
    logic [2:0] mst_axi_awprot;
    logic [3:0] mst_axi_awqos;
    logic mst_axi_awvalid, mst_axi_awready;
    logic [31:0] mst_axi_wdata;
    logic [3:0] mst_axi_wstrb;
    logic mst_axi_wlast, mst_axi_wvalid, mst_axi_wready;
    logic [3:0] mst_axi_bid;
    logic [1:0] mst_axi_bresp;
    logic mst_axi_bvalid, mst_axi_bready;
    logic [31:0] st_data;
    logic st_valid, st_startofpacket, st_endofpacket, st_ready;
    logic [4:0] ctrl_address;
    logic ctrl_read, ctrl_write;
    logic [31:0] ctrl_writedata;
    logic [3:0] ctrl_byteenable;
    logic [31:0] ctrl_readdata;
    logic [1:0] ctrl_response;
    logic ctrl_waitrequest;

    always #5 clk = ~clk;

    stream_to_axi_dma #(.ADDR_WIDTH(AW), .BURST_SIZE(BURST)) dut (
        .clk(clk), .rst(rst),
        .mst_axi_awid(mst_axi_awid), .mst_axi_awaddr(mst_axi_awaddr), .mst_axi_awlen(mst_axi_awlen),
        .mst_axi_awsize(mst_axi_awsize), .mst_axi_awburst(mst_axi_awburst),
        .mst_axi_awlock(mst_axi_awlock), .mst_axi_awcache(mst_axi_awcache),
        .mst_axi_awprot(mst_axi_awprot), .mst_axi_awqos(mst_axi_awqos),
        .mst_axi_awvalid(mst_axi_awvalid), .mst_axi_awready(mst_axi_awready),
        .mst_axi_wdata(mst_axi_wdata), .mst_axi_wstrb(mst_axi_wstrb), .mst_axi_wlast(mst_axi_wlast),
        .mst_axi_wvalid(mst_axi_wvalid), .mst_axi_wready(mst_axi_wready),
        .mst_axi_bid(mst_axi_bid), .mst_axi_bresp(mst_axi_bresp),
        .mst_axi_bvalid(mst_axi_bvalid), .mst_axi_bready(mst_axi_bready),
        .st_data(st_data), .st_valid(st_valid), .st_startofpacket(st_startofpacket),
        .st_endofpacket(st_endofpacket), .st_ready(st_ready),
        .ctrl_address(ctrl_address), .ctrl_read(ctrl_read), .ctrl_write(ctrl_write),
        .ctrl_writedata(ctrl_writedata), .ctrl_byteenable(ctrl_byteenable),
        .ctrl_readdata(ctrl_readdata), .ctrl_response(ctrl_response),
        .ctrl_waitrequest(ctrl_waitrequest)
    );

    int checks = 0;
    int failures = 0;

    word_t stim[$];
    word_t src_q[$];
    logic [AW-1:0] aw_q[$];
    logic [AW-1:0] exp_aw[$];
    beat_t w_q[$];
    beat_t exp_w[$];

    int exp_frames, st_taken, b_pend, b_idx, bad_burst;
    logic exp_early, exp_miss;
    bit stall, rand_sop, aw_wait, w_wait;
    logic [AW-1:0] aw_held;
    logic [37:0] w_held;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        st_valid = 0; st_data = 0; st_startofpacket = 0; st_endofpacket = 0;
        mst_axi_awready = 0; mst_axi_wready = 0; mst_axi_bvalid = 0;
        mst_axi_bresp = 0; mst_axi_bid = 0;
        ctrl_address = 0; ctrl_read = 0; ctrl_write = 0; ctrl_writedata = 0; ctrl_byteenable = 0;
        stim.delete(); src_q.delete(); aw_q.delete(); w_q.delete();
        st_taken = 0; b_pend = 0; b_idx = 0; bad_burst = -1;
        stall = 0; rand_sop = 0; aw_wait = 0; w_wait = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // One clock of all bench agents; entered and left just after a falling edge.
    task automatic step();
        logic st_hs;
        if (!st_valid && src_q.size() > 0 && (!stall || $urandom_range(3) != 0)) begin
            st_valid = 1; st_data = src_q[0].d;
            st_startofpacket = src_q[0].sop; st_endofpacket = src_q[0].eop;
        end
        mst_axi_awready = !stall || ($urandom_range(1) == 1);
        mst_axi_wready  = !stall || ($urandom_range(2) != 0);
        mst_axi_bvalid  = (b_pend > 0) && (!stall || ($urandom_range(1) == 1));
        mst_axi_bresp   = (b_idx == bad_burst) ? 2'b10 : 2'b00;
        #1;
        if (aw_wait) chk("aw_hold", {mst_axi_awvalid, mst_axi_awaddr}, {1'b1, aw_held});
        if (w_wait)
            chk("w_hold", {mst_axi_wvalid, mst_axi_wstrb, mst_axi_wlast,
                           (mst_axi_wstrb != 0) ? mst_axi_wdata : 32'h0}, w_held);
        if (mst_axi_awvalid) chk("one_outstanding", b_pend, 0);
        if (mst_axi_awvalid && mst_axi_awready) aw_q.push_back(mst_axi_awaddr);
        if (mst_axi_wvalid && mst_axi_wready) begin
            chk("aw_before_w", w_q.size() < aw_q.size() * BURST, 1);
            w_q.push_back({mst_axi_wdata, mst_axi_wstrb, mst_axi_wlast});
            if (mst_axi_wlast) b_pend++;
        end
        if (mst_axi_bvalid && mst_axi_bready) begin b_pend--; b_idx++; end
        st_hs   = st_valid && st_ready;
        aw_wait = mst_axi_awvalid && !mst_axi_awready;
        aw_held = mst_axi_awaddr;
        w_wait  = mst_axi_wvalid && !mst_axi_wready;
        w_held  = {mst_axi_wvalid, mst_axi_wstrb, mst_axi_wlast,
                   (mst_axi_wstrb != 0) ? mst_axi_wdata : 32'h0};
        @(posedge clk);
        @(negedge clk);
        if (st_hs) begin
            void'(src_q.pop_front());
            st_valid = 0; st_startofpacket = 0; st_endofpacket = 0;
            st_taken++;
        end
    endtask

    task automatic ctrl_wr(input logic [4:0] a, input logic [31:0] d);
        ctrl_address = a; ctrl_writedata = d; ctrl_byteenable = 4'hF; ctrl_write = 1;
        step();
        ctrl_write = 0;
    endtask

    task automatic ctrl_rd(input logic [4:0] a, output logic [31:0] d, output logic [1:0] r);
        ctrl_address = a; ctrl_read = 1;
        #1;
        d = ctrl_readdata; r = ctrl_response;
        ctrl_read = 0;
    endtask

    task automatic add_frame(input int len, input int eop_at, input int junk);
        word_t w;
        for (int k = 0; k < junk; k++) begin
            w.d = $urandom; w.sop = 0; w.eop = 0; stim.push_back(w);
        end
        for (int k = 0; k < len; k++) begin
            w.d = $urandom;
            w.sop = (k == 0) || (rand_sop && $urandom_range(7) == 0);
            w.eop = (k == eop_at);
            stim.push_back(w);
        end
    endtask

    // Frame-level expectation: which words reach memory, where, and with which flags.
    task automatic model(input logic [AW-1:0] start, input int words);
        int i, consumed;
        logic [AW-1:0] a;
        beat_t b;
        exp_aw.delete(); exp_w.delete();
        exp_frames = 0; exp_early = 0; exp_miss = 0;
        i = 0;
        while (i < stim.size()) begin
            if (!stim[i].sop) begin i++; continue; end
            a = start;
            consumed = words;
            for (int j = 0; j < words; j++) begin
                if (j % BURST == 0) begin exp_aw.push_back(a); a = a + AW'(BURST * 4); end
                b.d = stim[i+j].d; b.s = 4'hF; b.l = (j % BURST == BURST - 1);
                exp_w.push_back(b);
                if (stim[i+j].eop && j < words - 1) begin
                    exp_early = 1;
                    consumed = j + 1;
                    for (int p = j + 1; p % BURST != 0; p++) begin
                        b.d = 0; b.s = 4'h0; b.l = (p % BURST == BURST - 1);
                        exp_w.push_back(b);
                    end
                    break;
                end
            end
            if (consumed == words && !stim[i+words-1].eop) exp_miss = 1;
            exp_frames++;
            i += consumed;
        end
    endtask

    task automatic run(input int exp_beats, input string tag);
        int n;
        n = 0;
        while (!(w_q.size() >= exp_beats && b_pend == 0 && src_q.size() == 0) && n < 3000) begin
            step();
            n++;
        end
        chk({tag, "_timeout"}, n < 3000, 1);
        repeat (4) step();
    endtask

    task automatic compare_run(input string tag);
        chk({tag, "_aw_count"}, aw_q.size(), exp_aw.size());
        for (int k = 0; k < aw_q.size() && k < exp_aw.size(); k++)
            chk({tag, "_awaddr"}, aw_q[k], exp_aw[k]);
        chk({tag, "_beat_count"}, w_q.size(), exp_w.size());
        for (int k = 0; k < w_q.size() && k < exp_w.size(); k++) begin
            chk({tag, "_wstrb_wlast"}, {w_q[k].s, w_q[k].l}, {exp_w[k].s, exp_w[k].l});
            if (exp_w[k].s == 4'hF) chk({tag, "_wdata"}, w_q[k].d, exp_w[k].d);
        end
    endtask

    task automatic check_status(input string tag, input logic busy, input logic bresp_err);
        logic [31:0] rd;
        logic [1:0] rs;
        ctrl_rd(5'h0C, rd, rs);
        chk(tag, rd, {exp_frames[15:0], 12'h000, bresp_err, exp_miss, exp_early, busy});
    endtask

    task automatic run_scenario(input string tag, input logic [AW-1:0] start, input int words);
        ctrl_wr(5'h00, 32'(start));
        ctrl_wr(5'h04, words);
        ctrl_wr(5'h08, 32'h1);
        model(start, words);
        src_q = stim;
        run(exp_w.size(), tag);
        compare_run(tag);
        check_status({tag, "_status"}, 1'b1, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic [1:0] rs;
        logic busy;
        int n;

        do_reset();
        chk("rst_valids", {mst_axi_awvalid, mst_axi_wvalid, mst_axi_bready, st_ready, mst_axi_wlast},
            5'b0);
        chk("rst_awaddr", mst_axi_awaddr, 0);
        chk("aw_constants", {mst_axi_awid, mst_axi_awlen, mst_axi_awsize, mst_axi_awburst,
                             mst_axi_awlock, mst_axi_awcache, mst_axi_awprot, mst_axi_awqos,
                             ctrl_waitrequest}, {4'h0, 8'd3, 3'b010, 2'b01, 1'b0, 4'h0, 3'h0, 4'h0, 1'b0});
        ctrl_rd(5'h00, rd, rs); chk("rst_start", rd, 0);
        ctrl_rd(5'h04, rd, rs); chk("rst_words", rd, 0);
        ctrl_rd(5'h08, rd, rs); chk("rst_ctrl", rd, 0);
        ctrl_rd(5'h0C, rd, rs); chk("rst_status", {rd, rs}, 0);

        // single frame, no back-pressure
        add_frame(8, 7, 0);
        run_scenario("basic", 24'h001000, 8);
        chk("basic_aw1", aw_q[1], 24'h001010);

        // three frames with random stalls on every interface
        do_reset();
        rand_sop = 1;
        for (int f = 0; f < 3; f++) add_frame(8, 7, $urandom_range(0, 2));
        stall = 1;
        run_scenario("stall", 24'(($urandom_range(0, 255)) * 16), 8);

        // early EOP on word 6 of 8, then write-one-to-clear
        do_reset();
        add_frame(6, 5, 0);
        run_scenario("early", 24'h004000, 8);
        ctrl_wr(5'h0C, 32'h2);
        exp_early = 0;
        check_status("early_w1c", 1'b1, 1'b0);

        // missing EOP followed by trailing junk and a clean frame
        do_reset();
        add_frame(8, -1, 0);
        add_frame(8, 7, 2);
        run_scenario("missing", 24'h008000, 8);

        // junk words before the first SOP are dropped
        do_reset();
        add_frame(8, 7, 3);
        run_scenario("junk", 24'h00C000, 8);
        chk("junk_taken", st_taken, 11);

        // error response on first burst, then disable during the second burst
        do_reset();
        add_frame(16, 15, 0);
        bad_burst = 0;
        ctrl_wr(5'h00, 32'h2000);
        ctrl_wr(5'h04, 32'd16);
        ctrl_wr(5'h08, 32'h1);
        src_q = stim;
        n = 0;
        while (aw_q.size() < 2 && n < 500) begin step(); n++; end
        chk("dis_aw2_timeout", n < 500, 1);
        ctrl_wr(5'h08, 32'h0);
        n = 0; busy = 1;
        while (busy && n < 500) begin
            step();
            ctrl_rd(5'h0C, rd, rs);
            busy = rd[0];
            n++;
        end
        chk("dis_idle_timeout", n < 500, 1);
        chk("dis_aw_count", aw_q.size(), 2);
        chk("dis_aw1", aw_q[1], 24'h002010);
        chk("dis_beats", w_q.size(), 8);
        chk("dis_last_wlast", w_q[7].l, 1'b1);
        exp_frames = 0; exp_early = 0; exp_miss = 0;
        check_status("dis_status", 1'b0, 1'b1);

        // unmapped register and address wrap
        ctrl_rd(5'h14, rd, rs);
        chk("unmapped_read", {rs, rd}, {2'b10, 32'h0});
        ctrl_rd(5'h04, rd, rs);
        chk("mapped_read", {rs, rd}, {2'b00, 32'd16});
        do_reset();
        add_frame(8, 7, 0);
        run_scenario("wrap", 24'hFFFFF8, 8);
        chk("wrap_aw1", aw_q[1], 24'h000008);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
